// File: rtl/paddle_ctrl_gen.sv
// Two-paddle Pong controller: decodes keys or tracks the ball, accelerates held
// motion and clamps both paddle centres to the playfield once per frame.
//
// state | meaning
// IDLE  | no request, run count cleared, paddle holds
// UP    | moving toward Y_MIN (Y decreasing)
// DOWN  | moving toward Y_MAX (Y increasing)
module paddle_ctrl_gen #(
  parameter int P1_X         = 60,
  parameter int P2_X         = 550,
  parameter int Y_CENTER     = 240,
  parameter int Y_MIN        = 20,
  parameter int Y_MAX        = 461,
  parameter int HALF_LEN     = 35,
  parameter int HALF_WID     = 2,
  parameter int STEP_MIN     = 2,
  parameter int STEP_MAX     = 8,
  parameter int ACCEL_FRAMES = 4,
  parameter int CPU_STEP     = 3,
  parameter int CPU_DEADBAND = 4
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic       resetB,
  input  logic [7:0] keycode0,
  input  logic [7:0] keycode1,
  input  logic [1:0] cpu_mode,
  input  logic [9:0] BallY,
  output logic [9:0] Paddle1X,
  output logic [9:0] Paddle1Y,
  output logic [9:0] Paddle2X,
  output logic [9:0] Paddle2Y,
  output logic [9:0] PaddleL,
  output logic [9:0] PaddleW,
  output logic [1:0] at_top,
  output logic [1:0] at_bottom
);

  typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} dir_e;

  localparam logic signed [10:0] Y_TOP    = 11'(Y_MIN + HALF_LEN);
  localparam logic signed [10:0] Y_BOT    = 11'(Y_MAX - HALF_LEN);
  localparam logic [9:0]         Y_TOP10  = 10'(Y_MIN + HALF_LEN);
  localparam logic [9:0]         Y_BOT10  = 10'(Y_MAX - HALF_LEN);
  localparam logic signed [10:0] DEADBAND = 11'(CPU_DEADBAND);
  localparam logic [7:0]         ACC_SPAN = 8'(STEP_MAX - STEP_MIN);
  localparam logic [7:0]         ACC_DIV  = 8'(ACCEL_FRAMES);
  localparam logic [7:0]         RUN_SAT  = 8'hFF;

  logic [9:0] pad_y [2];

  assign Paddle1X = 10'(P1_X);
  assign Paddle2X = 10'(P2_X);
  assign PaddleL  = 10'(HALF_LEN);
  assign PaddleW  = 10'(HALF_WID);
  assign Paddle1Y = pad_y[0];
  assign Paddle2Y = pad_y[1];

  for (genvar i = 0; i < 2; i++) begin : g_pad
    localparam logic [7:0] KEY_UP = (i == 0) ? 8'h1A : 8'h52;
    localparam logic [7:0] KEY_DN = (i == 0) ? 8'h16 : 8'h51;

    dir_e              state_q, state_d;
    logic [7:0]        run_q, run_d, accel;
    logic [9:0]        y_q, y_d;
    logic              cpu_q, key_up, key_dn;
    logic signed [10:0] y_cur, ball_s, step, y_mv;

    always_comb begin
      key_up  = (keycode0 == KEY_UP) || (keycode1 == KEY_UP);
      key_dn  = (keycode0 == KEY_DN) || (keycode1 == KEY_DN);
      y_cur   = signed'({1'b0, y_q});
      ball_s  = signed'({1'b0, BallY});
      state_d = IDLE;
      if (cpu_mode[i]) begin
        if (ball_s < y_cur - DEADBAND)      state_d = UP;
        else if (ball_s > y_cur + DEADBAND) state_d = DOWN;
      end else if (key_up && !key_dn) begin
        state_d = UP;
      end else if (key_dn && !key_up) begin
        state_d = DOWN;
      end

      // A mode switch counts as a fresh run even when the direction is unchanged.
      run_d = 8'd0;
      if (state_d != IDLE) begin
        if (state_d == state_q && cpu_mode[i] == cpu_q)
          run_d = (run_q == RUN_SAT) ? RUN_SAT : run_q + 8'd1;
        else
          run_d = 8'd1;
      end

      accel = (run_d - 8'd1) / ACC_DIV;
      if (cpu_mode[i])          step = 11'(CPU_STEP);
      else if (accel >= ACC_SPAN) step = 11'(STEP_MAX);
      else                      step = 11'(STEP_MIN) + {3'b000, accel};

      y_mv = y_cur;
      if (state_d == UP)        y_mv = y_cur - step;
      else if (state_d == DOWN) y_mv = y_cur + step;

      if (y_mv < Y_TOP)      y_d = Y_TOP10;
      else if (y_mv > Y_BOT) y_d = Y_BOT10;
      else                   y_d = y_mv[9:0];
    end

    always_ff @(posedge frame_clk or posedge Reset) begin
      if (Reset) begin
        state_q <= IDLE;
        run_q   <= 8'd0;
        y_q     <= 10'(Y_CENTER);
        cpu_q   <= 1'b0;
      end else begin
        cpu_q <= cpu_mode[i];
        if (resetB) begin
          state_q <= IDLE;
          run_q   <= 8'd0;
          y_q     <= 10'(Y_CENTER);
        end else begin
          state_q <= state_d;
          run_q   <= run_d;
          y_q     <= y_d;
        end
      end
    end

    assign pad_y[i]     = y_q;
    assign at_top[i]    = (y_q == Y_TOP10);
    assign at_bottom[i] = (y_q == Y_BOT10);
  end

endmodule

// File: doc/paddle_ctrl_gen.md
# paddle_ctrl_gen

Parametrised two-paddle controller for the Pong datapath, successor to the fixed-step paddle block. Each frame it updates both paddle Y centres, clamped to the playfield, and exports paddle geometry to the ball/collision and drawing logic. It adds:
- two simultaneous keycode slots, so both players can hold keys at once;
- per-paddle acceleration while a key is held;
- exact boundary clamping, with no overshoot;
- an optional CPU-tracking mode per paddle.

## Interface
Parameters:
- P1_X, 60: left paddle X centre (constant output)
- P2_X, 550: right paddle X centre
- Y_CENTER, 240: Y centre after reset
- Y_MIN, 20 / Y_MAX, 461: playfield top/bottom limits for paddle edges
- HALF_LEN, 35: paddle half-length (exported on PaddleL)
- HALF_WID, 2: paddle half-width (exported on PaddleW)
- STEP_MIN, 2 / STEP_MAX, 8: manual step range, px/frame
- ACCEL_FRAMES, 4: consecutive frames per +1 step
- CPU_STEP, 3: CPU-mode step, px/frame
- CPU_DEADBAND, 4: CPU-mode tolerance around BallY

Ports:
- frame_clk  in  1  frame clock (vsync rate)
- Reset  in  1  asynchronous, active-high
- resetB  in  1  synchronous round restart, active-high
- keycode0, keycode1  in  8 each  USB keycode slots
- cpu_mode  in  2  bit0 = paddle 1 CPU-driven, bit1 = paddle 2 CPU-driven
- BallY  in  10  ball Y centre, CPU mode only
- Paddle1X, Paddle1Y, Paddle2X, Paddle2Y  out  10 each  paddle centres
- PaddleL, PaddleW  out  10 each  HALF_LEN and HALF_WID
- at_top, at_bottom  out  2 each  per paddle: edge at Y_MIN / Y_MAX

## Operation
**Key decode.** A key counts as pressed if it appears in either slot.
- Paddle 1: up = 0x1A (W), down = 0x16 (S).
- Paddle 2: up = 0x52, down = 0x51.
- Up and down pressed together, or neither pressed → no request.

**Per-paddle FSM.** States IDLE, UP, DOWN.
- Manual mode: the state follows the request each frame.
- On entry to UP/DOWN, including a direct reversal UP↔DOWN, the run count n resets to 1. n increments each further frame in the same state and saturates, no wrap.
- Step on the n-th frame = min(STEP_MIN + (n−1)/ACCEL_FRAMES, STEP_MAX), integer division.
- IDLE clears n; no motion.

**CPU mode** (cpu_mode bit set): keys for that paddle are ignored.
- BallY < Y − CPU_DEADBAND → UP.
- BallY > Y + CPU_DEADBAND → DOWN.
- Otherwise → IDLE.
- Step is always CPU_STEP; no acceleration.
- A cpu_mode change takes effect on the next edge and resets n.

**Position update.** Compute in 11-bit signed arithmetic.
- Ytop = Y_MIN + HALF_LEN (55); Ybot = Y_MAX − HALF_LEN (426).
- new Y = Y ∓ step, clamped to [Ytop, Ybot]. The position never leaves this range.
- A request toward an edge while already at that edge leaves Y unchanged. The FSM still enters UP/DOWN, so the run count keeps advancing.

**Flags.** at_top[i] = (Yi == Ytop); at_bottom[i] = (Yi == Ybot). Combinational from the registered Y.

## Timing
- All state updates on posedge frame_clk. Inputs are sampled at edge k, and the new Y is visible after edge k. There is no extra motion-register frame of lag.
- Reset (asynchronous) and resetB (synchronous, evaluated at the edge) both produce:
  - Paddle1Y = Paddle2Y = Y_CENTER = 240;
  - FSMs IDLE, n = 0;
  - at_top = at_bottom = 00.
- Constant outputs: Paddle1X = 60, Paddle2X = 550, PaddleL = 35, PaddleW = 2.
- Reset or resetB asserted mid-motion aborts the motion. Keys still held after release restart at n = 1, i.e. at STEP_MIN.
- Reset has priority over all inputs; resetB has priority over motion.
- The two paddles are fully independent. Simultaneous presses in different slots, e.g. keycode0 = 0x1A and keycode1 = 0x51, move both paddles on the same edge.

## Test plan
1. **Reset values.** Assert Reset → Paddle1Y = Paddle2Y = 240, at_top = at_bottom = 00, Paddle1X = 60, Paddle2X = 550, PaddleL = 35, PaddleW = 2.
2. **Acceleration.** Hold keycode0 = 0x1A for 8 frames → Paddle1Y = 238, 236, 234, 232, 229, 226, 223, 220; Paddle2Y stays 240. Then switch to 0x16 → 222 (reversal restarts at step 2).
3. **Bottom clamp.** Hold keycode1 = 0x51 → Paddle2Y reaches exactly 426 (no overshoot) and stays there while held; at_bottom = 10 (paddle 2 bit set).
4. **Conflicting and dual inputs.**
   - keycode0 = 0x1A, keycode1 = 0x16 → Paddle1Y unchanged.
   - keycode0 = 0x1A, keycode1 = 0x52 → both paddles move up by 2 on the same edge.
5. **CPU mode.** cpu_mode = 01, BallY = 100, from Y = 240 → Paddle1Y decreases by 3 per frame to 102, then holds. Keys 0x16 are ignored. BallY = 0 → Paddle1Y settles at 55 with at_top[0] = 1.
6. **Soft restart mid-motion.** After 6 frames holding W, pulse resetB for 1 edge → Paddle1Y = 240. The next held frame gives 238.
